// File: rtl/sequenciador_pkg.sv
// Shared definitions for sequenciador_movimentos and gerenciador_servos:
// FSM state encodings, move code constants and default move width.
package sequenciador_pkg;

  localparam int unsigned LARG_MOVE_PADRAO = 3;
  localparam int unsigned LARG_ESTADO      = 3;

  // FSM state encodings
  localparam logic [LARG_ESTADO-1:0] OCIOSO  = 3'd0;
  localparam logic [LARG_ESTADO-1:0] CARREGA = 3'd1;
  localparam logic [LARG_ESTADO-1:0] DISPARA = 3'd2;
  localparam logic [LARG_ESTADO-1:0] AGUARDA = 3'd3;
  localparam logic [LARG_ESTADO-1:0] FIM     = 3'd4;
  localparam logic [LARG_ESTADO-1:0] PAUSADO = 3'd5;

  // Move codes understood by gerenciador_servos
  localparam logic [LARG_MOVE_PADRAO-1:0] MOVE_U = 3'd0;
  localparam logic [LARG_MOVE_PADRAO-1:0] MOVE_D = 3'd1;
  localparam logic [LARG_MOVE_PADRAO-1:0] MOVE_L = 3'd2;
  localparam logic [LARG_MOVE_PADRAO-1:0] MOVE_R = 3'd3;
  localparam logic [LARG_MOVE_PADRAO-1:0] MOVE_F = 3'd4;
  localparam logic [LARG_MOVE_PADRAO-1:0] MOVE_B = 3'd5;

  // Where to go once a move is finished: next move if any is buffered, else finish
  function automatic logic [LARG_ESTADO-1:0] estado_apos_move(input logic vazio);
    return vazio ? FIM : CARREGA;
  endfunction

endpackage

// File: rtl/sequenciador_movimentos_fila.sv
// fila_movimentos: synchronous move FIFO with registered status flags and a
// sticky overflow flag. Depth must be a power of two so pointers wrap naturally.
module fila_movimentos #(
  parameter int unsigned PROFUNDIDADE = 64,
  parameter int unsigned LARG_MOVE    = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             limpar,
  input  logic                             escreve,
  input  logic [LARG_MOVE-1:0]             dado_in,
  input  logic                             le,
  output logic [LARG_MOVE-1:0]             dado_cabeca_c,
  output logic                             vazio,
  output logic                             cheio,
  output logic [$clog2(PROFUNDIDADE):0]    contagem,
  output logic                             erro_overflow
);

  localparam int unsigned LARG_PTR  = $clog2(PROFUNDIDADE);
  localparam int unsigned LARG_CONT = LARG_PTR + 1;

  logic [LARG_MOVE-1:0] r_mem [PROFUNDIDADE];
  logic [LARG_PTR-1:0]  r_ptr_esc;
  logic [LARG_PTR-1:0]  r_ptr_le;
  logic [LARG_CONT-1:0] r_cont;
  logic                 r_vazio;
  logic                 r_cheio;
  logic                 r_erro_overflow;
  logic [LARG_CONT-1:0] w_cont_prox;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_rejeita;

  assign w_pop     = le && !r_vazio && !limpar;
  assign w_push    = escreve && !limpar && (!r_cheio || w_pop);
  assign w_rejeita = escreve && !limpar && r_cheio && !w_pop;

  // Occupancy after this cycle's push/pop/clear
  always_comb begin
    w_cont_prox = r_cont;
    if (limpar) begin
      w_cont_prox = '0;
    end else if (w_push && !w_pop) begin
      w_cont_prox = r_cont + LARG_CONT'(1);
    end else if (w_pop && !w_push) begin
      w_cont_prox = r_cont - LARG_CONT'(1);
    end
  end

  // Pointers, occupancy, status flags and sticky overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr_esc       <= '0;
      r_ptr_le        <= '0;
      r_cont          <= '0;
      r_vazio         <= 1'b1;
      r_cheio         <= 1'b0;
      r_erro_overflow <= 1'b0;
    end else begin
      if (limpar) begin
        r_ptr_esc <= '0;
        r_ptr_le  <= '0;
      end else begin
        if (w_push) r_ptr_esc <= r_ptr_esc + LARG_PTR'(1);
        if (w_pop)  r_ptr_le  <= r_ptr_le + LARG_PTR'(1);
      end
      r_cont  <= w_cont_prox;
      r_vazio <= (w_cont_prox == '0);
      r_cheio <= (w_cont_prox == LARG_CONT'(PROFUNDIDADE));
      if (limpar) begin
        r_erro_overflow <= 1'b0;
      end else if (w_rejeita) begin
        r_erro_overflow <= 1'b1;
      end
    end
  end

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_ptr_esc] <= dado_in;
  end

  assign dado_cabeca_c = r_mem[r_ptr_le];
  assign vazio         = r_vazio;
  assign cheio         = r_cheio;
  assign contagem      = r_cont;
  assign erro_overflow = r_erro_overflow;

endmodule

// File: rtl/sequenciador_movimentos.sv
// sequenciador_movimentos: buffers solver moves and dispatches them one at a
// time to gerenciador_servos over the iniciar/pronto handshake.
// Optional macro SEQUENCIADOR_PAUSA_EN adds a pausa input and PAUSADO state.
module sequenciador_movimentos
  import sequenciador_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE   = 64,
  parameter int unsigned LARG_MOVE      = LARG_MOVE_PADRAO,
  parameter int unsigned TIMEOUT_CICLOS = 100_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          escreve,
  input  logic [LARG_MOVE-1:0]          move_in,
  input  logic                          iniciar,
  input  logic                          limpar,
  input  logic                          pronto_servo,
`ifdef SEQUENCIADOR_PAUSA_EN
  input  logic                          pausa,
`endif
  output logic                          iniciar_servo,
  output logic [LARG_MOVE-1:0]          move_servo,
  output logic                          ocupado,
  output logic                          fim,
  output logic                          vazio,
  output logic                          cheio,
  output logic [$clog2(PROFUNDIDADE):0] contagem,
  output logic                          erro_overflow,
  output logic                          erro_timeout
);

  localparam int unsigned LARG_TIMER = $clog2(TIMEOUT_CICLOS + 1);

  logic [LARG_ESTADO-1:0] r_estado;
  logic [LARG_ESTADO-1:0] w_prox_estado;
  logic [LARG_TIMER-1:0]  r_timer;
  logic [LARG_MOVE-1:0]   r_move_servo;
  logic                   r_iniciar_servo;
  logic                   r_ocupado;
  logic                   r_fim;
  logic                   r_erro_timeout;
  logic                   w_pop;
  logic                   w_timeout;
  logic                   w_vazio;
  logic [LARG_MOVE-1:0]   w_cabeca;

  fila_movimentos #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARG_MOVE    (LARG_MOVE)
  ) u_fila (
    .clock         (clock),
    .reset         (reset),
    .limpar        (limpar),
    .escreve       (escreve),
    .dado_in       (move_in),
    .le            (w_pop),
    .dado_cabeca_c (w_cabeca),
    .vazio         (w_vazio),
    .cheio         (cheio),
    .contagem      (contagem),
    .erro_overflow (erro_overflow)
  );

  // Next-state logic; limpar overrides every other input
  always_comb begin
    w_prox_estado = r_estado;
    w_pop         = 1'b0;
    w_timeout     = 1'b0;
    if (limpar) begin
      w_prox_estado = OCIOSO;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (iniciar) w_prox_estado = estado_apos_move(w_vazio);
        end
        CARREGA: begin
          w_pop         = !w_vazio;
          w_prox_estado = DISPARA;
        end
        DISPARA: begin
          w_prox_estado = AGUARDA;
        end
        AGUARDA: begin
          if (pronto_servo) begin
            w_prox_estado = estado_apos_move(w_vazio);
`ifdef SEQUENCIADOR_PAUSA_EN
            if (pausa) w_prox_estado = PAUSADO;
`endif
          end else if (r_timer == LARG_TIMER'(TIMEOUT_CICLOS - 1)) begin
            w_timeout     = 1'b1;
            w_prox_estado = OCIOSO;
          end
        end
`ifdef SEQUENCIADOR_PAUSA_EN
        PAUSADO: begin
          if (!pausa) w_prox_estado = estado_apos_move(w_vazio);
        end
`endif
        FIM: begin
          w_prox_estado = OCIOSO;
        end
        default: begin
          w_prox_estado = OCIOSO;
        end
      endcase
    end
  end

  // State register plus outputs registered from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado        <= OCIOSO;
      r_timer         <= '0;
      r_move_servo    <= '0;
      r_iniciar_servo <= 1'b0;
      r_ocupado       <= 1'b0;
      r_fim           <= 1'b0;
      r_erro_timeout  <= 1'b0;
    end else begin
      r_estado        <= w_prox_estado;
      r_iniciar_servo <= (w_prox_estado == DISPARA);
      r_ocupado       <= (w_prox_estado != OCIOSO);
      r_fim           <= (w_prox_estado == FIM);
      if (w_pop) r_move_servo <= w_cabeca;
      if (r_estado == DISPARA) begin
        r_timer <= '0;
      end else if (r_estado == AGUARDA) begin
        r_timer <= r_timer + LARG_TIMER'(1);
      end
      if (limpar) begin
        r_erro_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_erro_timeout <= 1'b1;
      end
    end
  end

  assign iniciar_servo = r_iniciar_servo;
  assign move_servo    = r_move_servo;
  assign ocupado       = r_ocupado;
  assign fim           = r_fim;
  assign vazio         = w_vazio;
  assign erro_timeout  = r_erro_timeout;

endmodule
